// File: rtl/led_matrix_scan_ctrl.sv
// Double-buffered row-scan driver for LED dot matrices; buffer swaps happen only at frame boundaries.
// Define LED_MATRIX_DIM_EN to add the 4-bit dim port for per-frame duty-cycle dimming.
module led_matrix_scan_ctrl #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ROW_W      = 3,
    parameter int SCAN_DIV   = 8192,
    parameter int BLANK_CYC  = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset,
`ifdef LED_MATRIX_DIM_EN
    input  logic [3:0]       dim,
`endif
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic             clr,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic [COLS-1:0]  segout,
    output logic [ROW_W-1:0] scanout,
    output logic             frame_start
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int LIM_W = CNT_W + 1;
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COLS-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

    logic [CNT_W-1:0] scan_cnt;
    logic             front_sel;
    logic             pending;
    logic [COLS-1:0]  fbuf [2][ROWS];

    logic             slot_end;
    logic             frame_end;
    logic             swap_now;
    logic             wr_ok;
    logic             seg_lit;
    logic [CNT_W-1:0] nxt_cnt;
    logic [ROW_W-1:0] nxt_row;
    logic             nxt_front;
    logic [LIM_W-1:0] lit_end;
    logic [COLS-1:0]  nxt_seg;
`ifdef LED_MATRIX_DIM_EN
    logic [3:0]       dim_q;
    logic [3:0]       nxt_dim;
`endif

    // segout is registered from next-cycle state so it lines up with scan_cnt/scanout.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        slot_end  = (scan_cnt == CNT_W'(SCAN_DIV - 1));
        frame_end = slot_end && (scanout == ROW_W'(ROWS - 1));
        swap_now  = frame_end && pending;
        wr_ok     = (int'(wr_row) < ROWS);
        nxt_cnt   = slot_end ? '0 : scan_cnt + CNT_W'(1);
        nxt_row   = scanout;
        if (slot_end) begin
            nxt_row = frame_end ? '0 : scanout + ROW_W'(1);
        end
        nxt_front = front_sel ^ swap_now;
`ifdef LED_MATRIX_DIM_EN
        nxt_dim   = frame_end ? dim : dim_q;
        lit_end   = LIM_W'(BLANK_CYC + ((int'(nxt_dim) + 1) * (SCAN_DIV - BLANK_CYC)) / 16);
`else
        lit_end   = LIM_W'(SCAN_DIV);
`endif
        seg_lit   = ({1'b0, nxt_cnt} >= LIM_W'(BLANK_CYC)) && ({1'b0, nxt_cnt} < lit_end);
        nxt_seg   = SEG_OFF;
        if (seg_lit) begin
            nxt_seg = (ACTIVE_LOW != 0) ? ~fbuf[nxt_front][IDX_W'(nxt_row)]
                                        :  fbuf[nxt_front][IDX_W'(nxt_row)];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt    <= '0;
            scanout     <= '0;
            front_sel   <= 1'b0;
            pending     <= 1'b0;
            segout      <= SEG_OFF;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
`ifdef LED_MATRIX_DIM_EN
            dim_q       <= 4'hF;
`endif
            // NOTE: the frame buffers are plain flops, not RAM, so they can and must be reset to unlit.
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    fbuf[b][r] <= '0;
                end
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
            scan_cnt    <= nxt_cnt;
            scanout     <= nxt_row;
            front_sel   <= nxt_front;
            pending     <= swap_req | (pending & ~swap_now);
            segout      <= nxt_seg;
            frame_start <= frame_end;
            swap_ack    <= swap_now;
`ifdef LED_MATRIX_DIM_EN
            dim_q       <= nxt_dim;
`endif
            // Back buffer is chosen by the pre-swap select, so a swap-cycle write lands in the new front.
            if (clr) begin
                for (int r = 0; r < ROWS; r++) begin
                    fbuf[~front_sel][r] <= '0;
                end
            end
            if (wr_en && wr_ok) begin
                fbuf[~front_sel][IDX_W'(wr_row)] <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl: 8x8 matrix, 4 blanking cycles, active-low columns.
// Expected frames are built from hand-written row images and a per-cycle slot/row position.
module tb_led_matrix_scan_ctrl;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int ROW_W = 4;
    localparam int BLANK = 4;
`ifdef LED_MATRIX_DIM_EN
    localparam int SD = 36;
`else
    localparam int SD = 16;
`endif
    localparam int FRAME = ROWS * SD;

    typedef logic [7:0] img_t [8];

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_en = 1'b0;
    logic             clr = 1'b0;
    logic             swap_req = 1'b0;
    logic [ROW_W-1:0] wr_row = '0;
    logic [7:0]       wr_data = '0;
    logic             swap_ack;
    logic             frame_start;
    logic [7:0]       segout;
    logic [ROW_W-1:0] scanout;
`ifdef LED_MATRIX_DIM_EN
    logic [3:0]       dim = 4'hF;
`endif

    int n_checks = 0;
    int n_pass = 0;

    led_matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .SCAN_DIV(SD),
        .BLANK_CYC(BLANK), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef LED_MATRIX_DIM_EN
        .dim(dim),
`endif
        .wr_en(wr_en),
        .wr_row(wr_row),
        .wr_data(wr_data),
        .clr(clr),
        .swap_req(swap_req),
        .swap_ack(swap_ack),
        .segout(segout),
        .scanout(scanout),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic write_row(input int row, input logic [7:0] data);
        wr_row  = ROW_W'(row);
        wr_data = data;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME && !ok; i++) begin
            if (frame_start === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    // Starts at the negedge of a frame's first cycle; returns at the next frame's first cycle.
    task automatic sweep_frame(input img_t img, input int lit_end, input logic exp_ack,
                               output int errs, output string first);
        int         r;
        int         c;
        logic [7:0] es;
        logic       efs;
        logic       eack;
        errs  = 0;
        first = "none";
        for (int k = 0; k < FRAME; k++) begin
            r    = k / SD;
            c    = k % SD;
            es   = (c >= BLANK && c < lit_end) ? ~img[r] : 8'hFF;
            efs  = (k == 0);
            eack = (k == 0) && exp_ack;
            if (segout !== es || scanout !== ROW_W'(r) || frame_start !== efs || swap_ack !== eack) begin
                if (errs == 0)
                    first = $sformatf("k=%0d segout=%h want %h scanout=%0d want %0d fs=%b want %b ack=%b want %b",
                                      k, segout, es, scanout, r, frame_start, efs, swap_ack, eack);
                errs++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int errs;
        int period;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (segout !== 8'hFF) $display("FAIL reset_segout: got %h want ff", segout);
        else n_pass++;
        n_checks++;
        if (scanout !== '0) $display("FAIL reset_scanout: got %0d want 0", scanout);
        else n_pass++;
        n_checks++;
        if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", frame_start);
        else n_pass++;
        n_checks++;
        if (swap_ack !== 1'b0) $display("FAIL reset_swap_ack: got %b want 0", swap_ack);
        else n_pass++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        errs = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (scanout !== ROW_W'(k / SD) || frame_start !== 1'b0 || segout !== 8'hFF) errs++;
            @(negedge clk);
        end
        n_checks++;
        if (errs !== 0) $display("FAIL scan_step: %0d cycles wrong, want 0", errs);
        else n_pass++;
        n_checks++;
        if (frame_start !== 1'b1 || scanout !== '0)
            $display("FAIL scan_wrap: frame_start=%b scanout=%0d want 1 and 0", frame_start, scanout);
        else n_pass++;
        period = 0;
        @(negedge clk);
        period = 1;
        while (frame_start !== 1'b1 && period < 2 * FRAME) begin
            @(negedge clk);
            period++;
        end
        n_checks++;
        if (period !== FRAME) $display("FAIL frame_period: got %0d cycles want %0d", period, FRAME);
        else n_pass++;
    endtask

    task automatic test_swap();
        img_t  z;
        img_t  a;
        int    e1;
        int    e2;
        string f1;
        string f2;
        z = '{default: 8'h00};
        a = z;
        a[3] = 8'h81;
        fork
            sweep_frame(z, SD, 1'b0, e1, f1);
            begin
                write_row(3, 8'h81);
                repeat (48) @(negedge clk);
                pulse_swap();
            end
        join
        n_checks++;
        if (e1 !== 0) $display("FAIL swap_pre_frame: %0d bad cycles, first %s", e1, f1);
        else n_pass++;
        sweep_frame(a, SD, 1'b1, e2, f2);
        n_checks++;
        if (e2 !== 0) $display("FAIL swap_post_frame: %0d bad cycles, first %s", e2, f2);
        else n_pass++;
    endtask

    task automatic test_blanking();
        bit ok;
        int n;
        for (int r = 0; r < ROWS; r++) write_row(r, 8'(8'h01 << r));
        pulse_swap();
        wait_frame(ok);
        n_checks++;
        if (ok !== 1'b1 || swap_ack !== 1'b1)
            $display("FAIL blank_swap: frame_start seen=%b swap_ack=%b want 1 and 1", ok, swap_ack);
        else n_pass++;
        for (int r = 0; r < ROWS; r++) begin
            n = 0;
            while (segout === 8'hFF && n < SD) begin
                n++;
                @(negedge clk);
            end
            n_checks++;
            if (n !== BLANK || segout !== ~(8'h01 << r) || scanout !== ROW_W'(r))
                $display("FAIL blank_row%0d: blank=%0d segout=%h scanout=%0d want %0d, %h, %0d",
                         r, n, segout, scanout, BLANK, ~(8'h01 << r), r);
            else n_pass++;
            repeat (SD - n) @(negedge clk);
        end
    endtask

    task automatic test_boundary();
        img_t  p;
        img_t  b;
        int    e1;
        int    e2;
        string f1;
        string f2;
        for (int r = 0; r < ROWS; r++) p[r] = 8'(8'h01 << r);
        b = '{default: 8'h00};
        b[2] = 8'h0F;
        fork
            sweep_frame(p, SD, 1'b0, e1, f1);
            begin
                clr = 1'b1;
                write_row(2, 8'h0F);
                clr = 1'b0;
                write_row(9, 8'hAA);
                pulse_swap();
            end
        join
        n_checks++;
        if (e1 !== 0) $display("FAIL bound_front_kept: %0d bad cycles, first %s", e1, f1);
        else n_pass++;
        sweep_frame(b, SD, 1'b1, e2, f2);
        n_checks++;
        if (e2 !== 0) $display("FAIL bound_clr_write: %0d bad cycles, first %s", e2, f2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        img_t  b;
        img_t  c;
        img_t  z;
        int    e;
        string f;
        bit    ok;
        z = '{default: 8'h00};
        b = z;
        b[2] = 8'h0F;
        c = z;
        c[5] = 8'h3C;
        fork
            sweep_frame(b, SD, 1'b0, e, f);
            begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                repeat (9) @(negedge clk);
                pulse_swap();
                repeat (FRAME - 12) @(negedge clk);
                swap_req = 1'b1;
                wr_en    = 1'b1;
                wr_row   = ROW_W'(5);
                wr_data  = 8'h3C;
                @(negedge clk);
                swap_req = 1'b0;
                wr_en    = 1'b0;
            end
        join
        n_checks++;
        if (e !== 0) $display("FAIL b2b_pre_frame: %0d bad cycles, first %s", e, f);
        else n_pass++;
        sweep_frame(c, SD, 1'b1, e, f);
        n_checks++;
        if (e !== 0) $display("FAIL b2b_swap_cycle_write: %0d bad cycles, first %s", e, f);
        else n_pass++;
        sweep_frame(b, SD, 1'b1, e, f);
        n_checks++;
        if (e !== 0) $display("FAIL b2b_repended_swap: %0d bad cycles, first %s", e, f);
        else n_pass++;

        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        repeat (5 * SD + 6) @(negedge clk);
        n_checks++;
        if (scanout !== ROW_W'(5)) $display("FAIL mid_row5_position: scanout=%0d want 5", scanout);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (scanout !== '0 || segout !== 8'hFF || frame_start !== 1'b0 || swap_ack !== 1'b0)
            $display("FAIL mid_reset_outputs: scanout=%0d segout=%h fs=%b ack=%b want 0 ff 0 0",
                     scanout, segout, frame_start, swap_ack);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_frame(ok);
        n_checks++;
        if (ok !== 1'b1 || swap_ack !== 1'b0)
            $display("FAIL reset_drops_pending: frame_start seen=%b swap_ack=%b want 1 and 0", ok, swap_ack);
        else n_pass++;
        sweep_frame(z, SD, 1'b0, e, f);
        n_checks++;
        if (e !== 0) $display("FAIL reset_clears_buffers: %0d bad cycles, first %s", e, f);
        else n_pass++;
    endtask

`ifdef LED_MATRIX_DIM_EN
    task automatic test_dim();
        img_t  d;
        int    e;
        string f;
        bit    ok;
        d = '{default: 8'h55};
        for (int r = 0; r < ROWS; r++) write_row(r, 8'h55);
        dim = 4'd7;
        pulse_swap();
        wait_frame(ok);
        n_checks++;
        if (ok !== 1'b1 || swap_ack !== 1'b1)
            $display("FAIL dim_swap: frame_start seen=%b swap_ack=%b want 1 and 1", ok, swap_ack);
        else n_pass++;
        fork
            sweep_frame(d, 20, 1'b1, e, f);
            begin
                repeat (40) @(negedge clk);
                dim = 4'd0;
            end
        join
        n_checks++;
        if (e !== 0) $display("FAIL dim7_window: %0d bad cycles, first %s", e, f);
        else n_pass++;
        sweep_frame(d, 6, 1'b0, e, f);
        n_checks++;
        if (e !== 0) $display("FAIL dim0_next_frame: %0d bad cycles, first %s", e, f);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_swap();
        test_blanking();
        test_boundary();
        test_back_to_back();
`ifdef LED_MATRIX_DIM_EN
        test_dim();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
